// File: rtl/ev3a_pkg.sv
// Shared widths, population size and loader FSM encoding for the EV3A population loader.
package ev3a_pkg;
  localparam int DEF_INT8_LENGTH       = 8;
  localparam int DEF_ENERGY_LENGTH     = 4;
  localparam int DEF_PARTICLE_LENGTH   = 2;
  localparam int DEF_LATTICE_LENGTH    = 11;
  localparam int DEF_IND_FIT_LENGTH    = 10;
  localparam int DEF_INDIVIDUAL_LENGTH = DEF_LATTICE_LENGTH * DEF_PARTICLE_LENGTH;
  localparam int DEF_NUM_PARTICLE_TYPE = 3;
  localparam int DEF_POP_SIZE          = 40;
  localparam int IDX_W                 = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } ld_state_e;
endpackage

// File: rtl/ev3a_pop_loader_if.sv
// Load-side beat bundle: individuals plus self- and interaction-energy entries.
interface ev3a_pop_loader_if;
  import ev3a_pkg::*;
  logic                             in_valid_ind;
  logic                             in_valid_self;
  logic                             in_valid_interact;
  logic [DEF_INT8_LENGTH-1:0]       Mutate_rate_in;
  logic [DEF_INDIVIDUAL_LENGTH-1:0] ind_state_in;
  logic [DEF_IND_FIT_LENGTH-1:0]    ind_fit_in;
  logic [DEF_ENERGY_LENGTH-1:0]     self_energy_in;
  logic [DEF_ENERGY_LENGTH-1:0]     interact_energy_in;

  modport master (
    output in_valid_ind, in_valid_self, in_valid_interact,
    output Mutate_rate_in, ind_state_in, ind_fit_in,
    output self_energy_in, interact_energy_in
  );
  modport slave (
    input in_valid_ind, in_valid_self, in_valid_interact,
    input Mutate_rate_in, ind_state_in, ind_fit_in,
    input self_energy_in, interact_energy_in
  );
endinterface

// File: rtl/ev3a_pop_ram.sv
// Population store: one write port, one registered read port that returns zero past DEPTH.
module ev3a_pop_ram #(
  parameter int DEPTH = 40,
  parameter int DW    = 40,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Only the read register is reset; the array contents survive rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (raddr < AW'(DEPTH)) rdata_q <= mem_q[raddr];
    else rdata_q <= '0;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/ev3a_pop_loader.sv
// Streams a GA population and its energy tables into local storage and tracks the fittest loaded individual.
module ev3a_pop_loader
  import ev3a_pkg::*;
#(
  parameter int INT8_LENGTH       = DEF_INT8_LENGTH,
  parameter int ENERGY_LENGTH     = DEF_ENERGY_LENGTH,
  parameter int PARTICLE_LENGTH   = DEF_PARTICLE_LENGTH,
  parameter int LATTICE_LENGTH    = DEF_LATTICE_LENGTH,
  parameter int IND_FIT_LENGTH    = DEF_IND_FIT_LENGTH,
  parameter int INDIVIDUAL_LENGTH = LATTICE_LENGTH * PARTICLE_LENGTH,
  parameter int NUM_PARTICLE_TYPE = DEF_NUM_PARTICLE_TYPE,
  parameter int POP_SIZE          = DEF_POP_SIZE
) (
  input  logic                                            clk,
  input  logic                                            rst,
  ev3a_pop_loader_if.slave                                ld,
  input  logic                                            release_i,
  input  logic [IDX_W-1:0]                                rd_idx,
  output logic [INDIVIDUAL_LENGTH-1:0]                    rd_state,
  output logic [INT8_LENGTH-1:0]                          rd_mut,
  output logic [IND_FIT_LENGTH-1:0]                       rd_fit,
  output logic [NUM_PARTICLE_TYPE*ENERGY_LENGTH-1:0]      self_tab,
  output logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*ENERGY_LENGTH-1:0] inter_tab,
  output logic [IND_FIT_LENGTH-1:0]                       init_min_fit,
  output logic [IDX_W-1:0]                                init_best_idx,
  output logic                                            ready,
  output logic                                            load_done,
  output logic                                            err_short,
  output logic                                            err_over
);
  localparam int INTER_N = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE;
  localparam int SC_W    = $clog2(NUM_PARTICLE_TYPE + 1);
  localparam int IC_W    = $clog2(INTER_N + 1);
  localparam int ROW_W   = INDIVIDUAL_LENGTH + INT8_LENGTH + IND_FIT_LENGTH;
  localparam int ST_W    = NUM_PARTICLE_TYPE * ENERGY_LENGTH;
  localparam int IT_W    = INTER_N * ENERGY_LENGTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_SIZE - 1);
  localparam logic [SC_W-1:0]  SELF_NUM = SC_W'(NUM_PARTICLE_TYPE);
  localparam logic [IC_W-1:0]  INTR_NUM = IC_W'(INTER_N);

  ld_state_e                 state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic [SC_W-1:0]           self_cnt_q, self_cnt_d;
  logic [IC_W-1:0]           inter_cnt_q, inter_cnt_d;
  logic [ST_W-1:0]           self_tab_q, self_tab_d;
  logic [IT_W-1:0]           inter_tab_q, inter_tab_d;
  logic [IND_FIT_LENGTH-1:0] min_fit_q, min_fit_d;
  logic [IDX_W-1:0]          best_q, best_d;
  logic                      ready_q, ready_d;
  logic                      done_q, done_d;
  logic                      err_short_q, err_short_d;
  logic                      err_over_q, err_over_d;
  logic                      we;
  logic [IDX_W-1:0]          waddr;
  logic [ROW_W-1:0]          rdata;
  logic                      any_valid;

  assign any_valid = ld.in_valid_ind | ld.in_valid_self | ld.in_valid_interact;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      self_cnt_q  <= '0;
      inter_cnt_q <= '0;
      self_tab_q  <= '0;
      inter_tab_q <= '0;
      min_fit_q   <= '0;
      best_q      <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_over_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      self_cnt_q  <= self_cnt_d;
      inter_cnt_q <= inter_cnt_d;
      self_tab_q  <= self_tab_d;
      inter_tab_q <= inter_tab_d;
      min_fit_q   <= min_fit_d;
      best_q      <= best_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_short_q <= err_short_d;
      err_over_q  <= err_over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    self_cnt_d  = self_cnt_q;
    inter_cnt_d = inter_cnt_q;
    self_tab_d  = self_tab_q;
    inter_tab_d = inter_tab_q;
    min_fit_d   = min_fit_q;
    best_d      = best_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    err_short_d = err_short_q;
    err_over_d  = err_over_q;
    we          = 1'b0;
    waddr       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ld.in_valid_ind) begin
          we        = 1'b1;
          waddr     = '0;
          cnt_d     = IDX_W'(1);
          min_fit_d = ld.ind_fit_in;
          best_d    = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld.in_valid_ind) begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
          // Strict less-than keeps the earliest index on fitness ties.
          if (ld.ind_fit_in < min_fit_q) begin
            min_fit_d = ld.ind_fit_in;
            best_d    = cnt_q;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = ST_READY;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          err_short_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_READY: begin
        if (release_i) begin
          state_d     = ST_IDLE;
          ready_d     = 1'b0;
          cnt_d       = '0;
          self_cnt_d  = '0;
          inter_cnt_d = '0;
          err_short_d = 1'b0;
          err_over_d  = 1'b0;
        end else if (any_valid) begin
          err_over_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Energy tables fill independently of the individual stream but freeze once the table is handed over.
    if (state_q != ST_READY) begin
      if (ld.in_valid_self) begin
        if (self_cnt_q < SELF_NUM) begin
          self_tab_d[self_cnt_q*ENERGY_LENGTH +: ENERGY_LENGTH] = ld.self_energy_in;
          self_cnt_d = self_cnt_q + 1'b1;
        end else begin
          err_over_d = 1'b1;
        end
      end
      if (ld.in_valid_interact) begin
        if (inter_cnt_q < INTR_NUM) begin
          inter_tab_d[inter_cnt_q*ENERGY_LENGTH +: ENERGY_LENGTH] = ld.interact_energy_in;
          inter_cnt_d = inter_cnt_q + 1'b1;
        end else begin
          err_over_d = 1'b1;
        end
      end
    end
  end

  ev3a_pop_ram #(
    .DEPTH (POP_SIZE),
    .DW    (ROW_W),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata ({ld.ind_state_in, ld.Mutate_rate_in, ld.ind_fit_in}),
    .raddr (rd_idx),
    .rdata (rdata)
  );

  assign {rd_state, rd_mut, rd_fit} = rdata;
  assign self_tab      = self_tab_q;
  assign inter_tab     = inter_tab_q;
  assign init_min_fit  = min_fit_q;
  assign init_best_idx = best_q;
  assign ready         = ready_q;
  assign load_done     = done_q;
  assign err_short     = err_short_q;
  assign err_over      = err_over_q;
endmodule
